// File: rtl/sdr_tx_arbiter.sv
// Frame-aware round-robin AXIS arbiter for the SDR TX path.
// Grants change only at TLAST boundaries; a per-grant frame quota bounds path ownership.
module sdr_tx_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned AXIS_BYTES = 8,
    parameter int unsigned QUOTA_W    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_enable,
    input  logic [NUM_SRC-1:0]                cfg_src_mask,
    input  logic [QUOTA_W-1:0]                cfg_quota,
    input  logic [NUM_SRC*AXIS_BYTES*8-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*AXIS_BYTES-1:0]     s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                s_axis_tlast,
    output logic [NUM_SRC-1:0]                s_axis_tready,
    output logic [AXIS_BYTES*8-1:0]           m_axis_tdata,
    output logic [AXIS_BYTES-1:0]             m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic                              grant_valid,
    output logic [$clog2(NUM_SRC)-1:0]        grant_id,
    output logic [31:0]                       frame_count
);

    localparam int unsigned DW  = AXIS_BYTES * 8;
    localparam int unsigned IDW = $clog2(NUM_SRC);
    localparam logic [IDW:0] NSRC_W = (IDW+1)'(NUM_SRC);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state_q,      state_d;
    logic [IDW-1:0]        rr_ptr_q,     rr_ptr_d;
    logic [IDW-1:0]        gid_q,        gid_d;
    logic                  gvalid_q,     gvalid_d;
    logic [QUOTA_W-1:0]    frames_q,     frames_d;
    logic                  frame_open_q, frame_open_d;
    logic [DW-1:0]         m_data_q,     m_data_d;
    logic [AXIS_BYTES-1:0] m_keep_q,     m_keep_d;
    logic                  m_valid_q,    m_valid_d;
    logic                  m_last_q,     m_last_d;
    logic [31:0]           fcnt_q,       fcnt_d;

    logic [NUM_SRC-1:0]    eligible;
    logic [NUM_SRC-1:0]    gid_onehot;
    logic [NUM_SRC-1:0]    others;
    logic [2*NUM_SRC-1:0]  rot;
    logic                  win_found;
    logic [IDW:0]          win_sum;
    logic [IDW-1:0]        win_id;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_mask;
    logic [DW-1:0]         sel_data;
    logic [AXIS_BYTES-1:0] sel_keep;
    logic                  can_load;
    logic                  accept;
    logic [QUOTA_W-1:0]    quota_eff;

    // Granted-source mux and round-robin winner search starting at rr_ptr.
    always_comb begin
        eligible   = {NUM_SRC{cfg_enable}} & cfg_src_mask & s_axis_tvalid;
        gid_onehot = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_mask   = 1'b0;
        sel_data   = '0;
        sel_keep   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gid_q == IDW'(i)) begin
                gid_onehot[i] = 1'b1;
                sel_valid     = s_axis_tvalid[i];
                sel_last      = s_axis_tlast[i];
                sel_mask      = cfg_src_mask[i];
                sel_data      = s_axis_tdata[i*DW +: DW];
                sel_keep      = s_axis_tkeep[i*AXIS_BYTES +: AXIS_BYTES];
            end
        end
        others = eligible & ~gid_onehot;

        rot       = {eligible, eligible} >> rr_ptr_q;
        win_found = 1'b0;
        win_sum   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (rot[k] && !win_found) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            end
        end
        win_id = (win_sum >= NSRC_W) ? IDW'(win_sum - NSRC_W) : IDW'(win_sum);
    end

    // Next-state, output slice and frame accounting.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gid_d        = gid_q;
        gvalid_d     = gvalid_q;
        frames_d     = frames_q;
        frame_open_d = frame_open_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        fcnt_d       = fcnt_q;
        s_axis_tready = '0;

        can_load  = ~m_valid_q | m_axis_tready;
        quota_eff = (cfg_quota == '0) ? QUOTA_W'(1) : cfg_quota;
        accept    = (state_q == ST_GRANT) && can_load && sel_valid;

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
            if (m_last_q) begin
                fcnt_d = fcnt_q + 32'(1);
            end
        end
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_keep_d  = sel_keep;
            m_last_d  = sel_last;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d      = ST_GRANT;
                    gid_d        = win_id;
                    gvalid_d     = 1'b1;
                    frames_d     = '0;
                    frame_open_d = 1'b0;
                    rr_ptr_d     = (win_id == IDW'(NUM_SRC - 1)) ? '0 : win_id + IDW'(1);
                end
            end
            ST_GRANT: begin
                if (state_q == ST_GRANT) begin
                    s_axis_tready = gid_onehot & {NUM_SRC{can_load}};
                end
                if (accept) begin
                    frame_open_d = ~sel_last;
                    if (sel_last) begin
                        frames_d = frames_q + QUOTA_W'(1);
                    end
                end
                // Release only between frames, evaluated on the post-accept frame state.
                if (!frame_open_d &&
                    ((frames_d >= quota_eff) || !cfg_enable || !sel_mask ||
                     (!sel_valid && (others != '0)))) begin
                    state_d  = ST_IDLE;
                    gvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            gid_q        <= '0;
            gvalid_q     <= 1'b0;
            frames_q     <= '0;
            frame_open_q <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gid_q        <= gid_d;
            gvalid_q     <= gvalid_d;
            frames_q     <= frames_d;
            frame_open_q <= frame_open_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign grant_valid   = gvalid_q;
    assign grant_id      = gid_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_sdr_tx_arbiter.sv
// Bench for sdr_tx_arbiter: queue-driven sources, frame-level round-robin/quota model.
module tb_sdr_tx_arbiter;

    localparam int NS  = 4;
    localparam int KB  = 8;
    localparam int DW  = KB * 8;
    localparam int QW  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_enable;
    logic [NS-1:0]     cfg_src_mask;
    logic [QW-1:0]     cfg_quota;
    logic [NS*DW-1:0]  s_axis_tdata;
    logic [NS*KB-1:0]  s_axis_tkeep;
    logic [NS-1:0]     s_axis_tvalid;
    logic [NS-1:0]     s_axis_tlast;
    logic [NS-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KB-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              grant_valid;
    logic [IDW-1:0]    grant_id;
    logic [31:0]       frame_count;

    always #5 clk = ~clk;

    sdr_tx_arbiter #(.NUM_SRC(NS), .AXIS_BYTES(KB), .QUOTA_W(QW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_src_mask(cfg_src_mask),
        .cfg_quota(cfg_quota), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant_valid(grant_valid), .grant_id(grant_id), .frame_count(frame_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
        logic [7:0]    src;
    } beat_t;

    beat_t       srcq[NS][$];
    beat_t       refq[NS][$];
    int          reflen[NS][$];
    beat_t       expq[$];
    beat_t       outq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int proto_err;
    int rdy_pct;
    int first_mv;
    int fseq = 0;

    logic           obs_mv, obs_gv;
    logic [IDW-1:0] obs_gid;
    logic [31:0]    obs_fc;
    logic [NS-1:0]  obs_str;

    task automatic clear_q();
        for (int i = 0; i < NS; i++) begin
            srcq[i].delete();
            refq[i].delete();
            reflen[i].delete();
        end
        expq.delete();
        outq.delete();
    endtask

    task automatic load_frame(input int s, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {8'(s), 8'(fseq), 16'(k), $urandom()};
            b.keep = 8'($urandom_range(1, 255));
            b.last = (k == len - 1);
            b.src  = 8'(s);
            srcq[s].push_back(b);
            refq[s].push_back(b);
        end
        reflen[s].push_back(len);
        fseq++;
    endtask

    // Frame-level model: round-robin over masked sources with pending frames,
    // each grant carrying up to max(quota,1) whole frames.
    task automatic build_expected(input logic [NS-1:0] mask, input int quota, input int start);
        int q, ptr, found, n, len;
        q   = (quota == 0) ? 1 : quota;
        ptr = start;
        expq.delete();
        while (1) begin
            found = -1;
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (ptr + k) % NS;
                if (found < 0 && mask[s] && reflen[s].size() > 0) found = s;
            end
            if (found < 0) break;
            n = 0;
            while (n < q && reflen[found].size() > 0) begin
                len = reflen[found].pop_front();
                repeat (len) expq.push_back(refq[found].pop_front());
                n++;
            end
            ptr = (found + 1) % NS;
        end
    endtask

    // One clock: drive at negedge, observe settled values, commit handshakes after posedge.
    task automatic step();
        logic [NS-1:0] fire;
        logic          ofire;
        beat_t         ob;
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                s_axis_tvalid[i]            = 1'b1;
                s_axis_tdata[i*DW +: DW]    = srcq[i][0].data;
                s_axis_tkeep[i*KB +: KB]    = srcq[i][0].keep;
                s_axis_tlast[i]             = srcq[i][0].last;
            end else begin
                s_axis_tvalid[i]            = 1'b0;
                s_axis_tdata[i*DW +: DW]    = '0;
                s_axis_tkeep[i*KB +: KB]    = '0;
                s_axis_tlast[i]             = 1'b0;
            end
        end
        m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
        #1;
        obs_mv  = m_axis_tvalid;
        obs_gv  = grant_valid;
        obs_gid = grant_id;
        obs_fc  = frame_count;
        obs_str = s_axis_tready;
        if ($countones(s_axis_tready) > 1) proto_err++;
        if (m_axis_tvalid && !m_axis_tready && s_axis_tready != '0) proto_err++;
        if (!grant_valid && s_axis_tready != '0) proto_err++;
        if (first_mv < 0 && m_axis_tvalid) first_mv = cyc;
        fire    = s_axis_tvalid & s_axis_tready;
        ofire   = m_axis_tvalid & m_axis_tready;
        ob.data = m_axis_tdata;
        ob.keep = m_axis_tkeep;
        ob.last = m_axis_tlast;
        ob.src  = m_axis_tdata[DW-1 -: 8];
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) if (fire[i]) void'(srcq[i].pop_front());
        if (ofire) outq.push_back(ob);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        cfg_enable   = 1'b0;
        cfg_src_mask = '0;
        cfg_quota    = QW'(1);
        rdy_pct      = 100;
        clear_q();
        step();
        step();
        rst_n     = 1'b1;
        outq.delete();
        proto_err = 0;
        first_mv  = -1;
    endtask

    task automatic run_drain(input int n_exp, input int budget);
        int b = 0;
        while (outq.size() < n_exp && b < budget) begin
            step();
            b++;
        end
        repeat (8) step();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        total++; if (obs_mv !== 1'b0)  begin bad++; $display("FAIL reset_mvalid got=%b want=0", obs_mv); end
        total++; if (obs_gv !== 1'b0)  begin bad++; $display("FAIL reset_gvalid got=%b want=0", obs_gv); end
        total++; if (obs_gid !== '0)   begin bad++; $display("FAIL reset_gid got=%0d want=0", obs_gid); end
        total++; if (obs_fc !== 32'd0) begin bad++; $display("FAIL reset_fcount got=%0d want=0", obs_fc); end
        total++; if (obs_str !== '0)   begin bad++; $display("FAIL reset_tready got=%b want=0", obs_str); end
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b0001; cfg_quota = QW'(1);
        load_frame(0, 3);
        build_expected(4'b0001, 1, 0);
        c0 = cyc;
        run_drain(3, 50);
        total++; if (first_mv - c0 !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", first_mv - c0); end
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL single_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL single_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        total++; if (obs_fc !== 32'd1) begin bad++; $display("FAIL single_fcount got=%0d want=1", obs_fc); end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL single_proto got=%0d want=0", proto_err); end
    endtask

    task automatic test_round_robin();
        int fsrc[$];
        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b0111; cfg_quota = QW'(1);
        for (int f = 0; f < 2; f++) for (int s = 0; s < 3; s++) load_frame(s, 2);
        build_expected(4'b0111, 1, 0);
        run_drain(12, 200);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL rr_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL rr_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        foreach (outq[i]) if (outq[i].last) fsrc.push_back(int'(outq[i].src));
        total++; if (fsrc.size() !== 6) begin bad++; $display("FAIL rr_frames got=%0d want=6", fsrc.size()); end
        for (int i = 0; i < fsrc.size(); i++) begin
            total++; if (fsrc[i] !== i % 3) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, fsrc[i], i % 3); end
        end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL rr_proto got=%0d want=0", proto_err); end
    endtask

    task automatic test_quota();
        int fsrc[$];
        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b0011; cfg_quota = QW'(3);
        for (int f = 0; f < 6; f++) begin
            load_frame(0, $urandom_range(1, 3));
            load_frame(1, $urandom_range(1, 3));
        end
        build_expected(4'b0011, 3, 0);
        run_drain(expq.size(), 400);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL quota3_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL quota3_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        foreach (outq[i]) if (outq[i].last) fsrc.push_back(int'(outq[i].src));
        for (int i = 0; i < fsrc.size(); i++) begin
            total++; if (fsrc[i] !== (i / 3) % 2) begin bad++; $display("FAIL quota3_order[%0d] got=%0d want=%0d", i, fsrc[i], (i / 3) % 2); end
        end
        total++; if (obs_fc !== 32'd12) begin bad++; $display("FAIL quota3_fcount got=%0d want=12", obs_fc); end

        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b0011; cfg_quota = QW'(0);
        for (int f = 0; f < 3; f++) begin
            load_frame(0, 2);
            load_frame(1, 2);
        end
        build_expected(4'b0011, 0, 0);
        run_drain(expq.size(), 200);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL quota0_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL quota0_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b0001; cfg_quota = QW'(2);
        rdy_pct = 50;
        for (int f = 0; f < 8; f++) load_frame(0, $urandom_range(1, 5));
        build_expected(4'b0001, 2, 0);
        run_drain(expq.size(), 600);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL bp_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL bp_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL bp_proto got=%0d want=0", proto_err); end
        total++; if (obs_fc !== 32'd8) begin bad++; $display("FAIL bp_fcount got=%0d want=8", obs_fc); end
    endtask

    task automatic test_enable_drop();
        int b = 0;
        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b1111; cfg_quota = QW'(1);
        load_frame(0, 4);
        build_expected(4'b1111, 1, 0);
        while (srcq[0].size() > 2 && b < 50) begin step(); b++; end
        cfg_enable = 1'b0;
        run_drain(4, 50);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL endrop_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL endrop_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        total++; if (obs_gv !== 1'b0) begin bad++; $display("FAIL endrop_gvalid got=%b want=0", obs_gv); end
        total++; if (obs_str !== '0)  begin bad++; $display("FAIL endrop_tready got=%b want=0", obs_str); end
        outq.delete();
        load_frame(0, 2);
        load_frame(2, 2);
        repeat (5) step();
        total++; if (outq.size() !== 0) begin bad++; $display("FAIL endrop_hold got=%0d want=0", outq.size()); end
        build_expected(4'b1111, 1, 1);
        cfg_enable = 1'b1;
        run_drain(4, 100);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL reen_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL reen_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        if (outq.size() > 0) begin
            total++; if (outq[0].src !== 8'd2) begin bad++; $display("FAIL reen_first got=%0d want=2", outq[0].src); end
        end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL endrop_proto got=%0d want=0", proto_err); end
    endtask

    task automatic test_reset_mid();
        int b = 0;
        do_reset();
        cfg_enable = 1'b1; cfg_src_mask = 4'b0011; cfg_quota = QW'(1);
        load_frame(1, 2);
        run_drain(2, 50);
        total++; if (obs_fc !== 32'd1) begin bad++; $display("FAIL rmid_pre_fcount got=%0d want=1", obs_fc); end
        load_frame(1, 6);
        while (srcq[1].size() > 3 && b < 50) begin step(); b++; end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_q();
        step();
        total++; if (obs_mv !== 1'b0)  begin bad++; $display("FAIL rmid_mvalid got=%b want=0", obs_mv); end
        total++; if (obs_gv !== 1'b0)  begin bad++; $display("FAIL rmid_gvalid got=%b want=0", obs_gv); end
        total++; if (obs_fc !== 32'd0) begin bad++; $display("FAIL rmid_fcount got=%0d want=0", obs_fc); end
        outq.delete();
        load_frame(1, 2);
        load_frame(0, 2);
        build_expected(4'b0011, 1, 0);
        run_drain(4, 100);
        total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL rmid_len got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
            total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL rmid_beat[%0d] got=%h want=%h", i, outq[i], expq[i]); end
        end
        if (outq.size() > 0) begin
            total++; if (outq[0].src !== 8'd0) begin bad++; $display("FAIL rmid_first got=%0d want=0", outq[0].src); end
        end
        total++; if (obs_fc !== 32'd2) begin bad++; $display("FAIL rmid_fcount2 got=%0d want=2", obs_fc); end
    endtask

    task automatic test_random();
        logic [NS-1:0] mask;
        int q, nfr;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            mask    = 4'($urandom_range(1, 15));
            q       = $urandom_range(0, 3);
            rdy_pct = $urandom_range(30, 100);
            cfg_enable = 1'b1; cfg_src_mask = mask; cfg_quota = QW'(q);
            for (int s = 0; s < NS; s++) begin
                int nf;
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) load_frame(s, $urandom_range(1, 4));
            end
            build_expected(mask, q, 0);
            nfr = 0;
            foreach (expq[i]) if (expq[i].last) nfr++;
            run_drain(expq.size(), 2000);
            total++; if (outq.size() !== expq.size()) begin bad++; $display("FAIL rand%0d_len got=%0d want=%0d", it, outq.size(), expq.size()); end
            for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
                total++; if (outq[i] !== expq[i]) begin bad++; $display("FAIL rand%0d_beat[%0d] got=%h want=%h", it, i, outq[i], expq[i]); end
            end
            total++; if (obs_fc !== 32'(nfr)) begin bad++; $display("FAIL rand%0d_fcount got=%0d want=%0d", it, obs_fc, nfr); end
            total++; if (proto_err !== 0) begin bad++; $display("FAIL rand%0d_proto got=%0d want=0", it, proto_err); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        cfg_enable    = 1'b0;
        cfg_src_mask  = '0;
        cfg_quota     = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        proto_err     = 0;
        rdy_pct       = 100;
        first_mv      = -1;
        test_reset();
        test_single();
        test_round_robin();
        test_quota();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
